// File: rtl/cc_ball_shiftregister_pkg.sv
// Shared types and constants for the ball row shifter and its tick prescaler.
package cc_ball_shiftregister_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic DIR_P1 = 1'b0;  // ball travels toward bit0
    localparam logic DIR_P2 = 1'b1;  // ball travels toward the MSB

    // A single-cycle prescaler still needs a one-bit counter to exist.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/cc_ball_shiftregister_tick_prescaler.sv
// Divides the clock into shift ticks; the count is held at zero whenever disabled.
module cc_tick_prescaler
    import cc_ball_shiftregister_pkg::*;
#(
    parameter int PRESCALER_COUNT = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = cnt_width(PRESCALER_COUNT);
    localparam logic [CW-1:0] LAST = CW'(PRESCALER_COUNT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Terminal count while enabled: the owner shifts on this cycle's edge.
    assign tick = enable && (count == LAST);

endmodule

// File: rtl/cc_ball_shiftregister.sv
// Ball row shift register: serve/load, prescaled shifting, paddle bounce and exit detection.
module cc_ball_shiftregister
    import cc_ball_shiftregister_pkg::*;
#(
    parameter int DATAWIDTH       = 8,
    parameter int PRESCALER_COUNT = 10
) (
    input  logic                 CC_BALLSHIFTER_CLOCK_50,
    input  logic                 CC_BALLSHIFTER_RESET_InHigh,
    input  logic                 CC_BALLSHIFTER_serve_In,
    input  logic [DATAWIDTH-1:0] CC_BALLSHIFTER_data_InBUS,
    input  logic                 CC_BALLSHIFTER_dir_In,
    input  logic                 CC_BALLSHIFTER_hit1_In,
    input  logic                 CC_BALLSHIFTER_hit2_In,
    output logic [DATAWIDTH-1:0] CC_BALLSHIFTER_data_OutBUS,
    output logic                 CC_BALLSHIFTER_moving_Out,
    output logic                 CC_BALLSHIFTER_tick_Out,
    output logic                 CC_BALLSHIFTER_side_Out
);

    state_t               state;
    logic                 dir;
    logic                 run_en;
    logic                 shift_now;
    logic [DATAWIDTH-1:0] shifted;
    logic                 next_dir;

    assign run_en = (state == ST_RUN);

    cc_tick_prescaler #(
        .PRESCALER_COUNT(PRESCALER_COUNT)
    ) u_prescaler (
        .clock  (CC_BALLSHIFTER_CLOCK_50),
        .reset  (CC_BALLSHIFTER_RESET_InHigh),
        .enable (run_en),
        .tick   (shift_now)
    );

    // Only the paddle on the edge the ball is heading toward can bounce it.
    always_comb begin
        shifted  = CC_BALLSHIFTER_data_OutBUS >> 1;
        next_dir = dir;
        if (dir == DIR_P1) begin
            if (CC_BALLSHIFTER_data_OutBUS[0] && CC_BALLSHIFTER_hit1_In) begin
                shifted  = CC_BALLSHIFTER_data_OutBUS << 1;
                next_dir = DIR_P2;
            end else begin
                shifted  = CC_BALLSHIFTER_data_OutBUS >> 1;
            end
        end else begin
            if (CC_BALLSHIFTER_data_OutBUS[DATAWIDTH-1] && CC_BALLSHIFTER_hit2_In) begin
                shifted  = CC_BALLSHIFTER_data_OutBUS >> 1;
                next_dir = DIR_P1;
            end else begin
                shifted  = CC_BALLSHIFTER_data_OutBUS << 1;
            end
        end
    end

    always_ff @(posedge CC_BALLSHIFTER_CLOCK_50) begin
        if (CC_BALLSHIFTER_RESET_InHigh) begin
            state                      <= ST_IDLE;
            dir                        <= DIR_P1;
            CC_BALLSHIFTER_data_OutBUS <= '0;
            CC_BALLSHIFTER_moving_Out  <= 1'b0;
            CC_BALLSHIFTER_tick_Out    <= 1'b0;
            CC_BALLSHIFTER_side_Out    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    CC_BALLSHIFTER_tick_Out <= 1'b0;
                    if (CC_BALLSHIFTER_serve_In && (CC_BALLSHIFTER_data_InBUS != '0)) begin
                        CC_BALLSHIFTER_data_OutBUS <= CC_BALLSHIFTER_data_InBUS;
                        dir                        <= CC_BALLSHIFTER_dir_In;
                        state                      <= ST_RUN;
                        CC_BALLSHIFTER_moving_Out  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    CC_BALLSHIFTER_tick_Out <= shift_now;
                    if (shift_now) begin
                        // An empty row means the last set bit has left; side records where.
                        if (shifted == '0) begin
                            state                      <= ST_DONE;
                            CC_BALLSHIFTER_moving_Out  <= 1'b0;
                            CC_BALLSHIFTER_side_Out    <= dir;
                            CC_BALLSHIFTER_data_OutBUS <= '0;
                        end else begin
                            CC_BALLSHIFTER_data_OutBUS <= shifted;
                            dir                        <= next_dir;
                        end
                    end
                end
                default: begin
                    state                      <= ST_IDLE;
                    CC_BALLSHIFTER_data_OutBUS <= '0;
                    CC_BALLSHIFTER_moving_Out  <= 1'b0;
                    CC_BALLSHIFTER_tick_Out    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc_ball_shiftregister.sv
// Bench for the ball row shifter: two instances (prescale 4 and 1) against a behavioural model.
module tb_cc_ball_shiftregister;

    logic       clk = 1'b0;
    logic       rst     [2];
    logic       serve   [2];
    logic [7:0] din     [2];
    logic       dir_in  [2];
    logic       hit1    [2];
    logic       hit2    [2];
    logic [7:0] bus     [2];
    logic       moving  [2];
    logic       tick    [2];
    logic       side    [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Model state: whether a ball is in play, cycles since serve, and the visible outputs.
    bit       m_run     [2];
    int       m_elapsed [2];
    int       m_bus     [2];
    bit       m_dir     [2];
    bit       m_side    [2];
    bit       m_tick    [2];

    always #5 clk = ~clk;

    cc_ball_shiftregister #(.DATAWIDTH(8), .PRESCALER_COUNT(4)) dut0 (
        .CC_BALLSHIFTER_CLOCK_50     (clk),
        .CC_BALLSHIFTER_RESET_InHigh (rst[0]),
        .CC_BALLSHIFTER_serve_In     (serve[0]),
        .CC_BALLSHIFTER_data_InBUS   (din[0]),
        .CC_BALLSHIFTER_dir_In       (dir_in[0]),
        .CC_BALLSHIFTER_hit1_In      (hit1[0]),
        .CC_BALLSHIFTER_hit2_In      (hit2[0]),
        .CC_BALLSHIFTER_data_OutBUS  (bus[0]),
        .CC_BALLSHIFTER_moving_Out   (moving[0]),
        .CC_BALLSHIFTER_tick_Out     (tick[0]),
        .CC_BALLSHIFTER_side_Out     (side[0])
    );

    cc_ball_shiftregister #(.DATAWIDTH(8), .PRESCALER_COUNT(1)) dut1 (
        .CC_BALLSHIFTER_CLOCK_50     (clk),
        .CC_BALLSHIFTER_RESET_InHigh (rst[1]),
        .CC_BALLSHIFTER_serve_In     (serve[1]),
        .CC_BALLSHIFTER_data_InBUS   (din[1]),
        .CC_BALLSHIFTER_dir_In       (dir_in[1]),
        .CC_BALLSHIFTER_hit1_In      (hit1[1]),
        .CC_BALLSHIFTER_hit2_In      (hit2[1]),
        .CC_BALLSHIFTER_data_OutBUS  (bus[1]),
        .CC_BALLSHIFTER_moving_Out   (moving[1]),
        .CC_BALLSHIFTER_tick_Out     (tick[1]),
        .CC_BALLSHIFTER_side_Out     (side[1])
    );

    function automatic int pc(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    // One clock edge of the game rules, in plain integer arithmetic on the row value.
    task automatic model_step(input int i);
        int b;
        bit nd;
        if (rst[i]) begin
            m_run[i] = 0; m_elapsed[i] = 0; m_bus[i] = 0;
            m_dir[i] = 0; m_side[i] = 0; m_tick[i] = 0;
        end else if (!m_run[i]) begin
            m_tick[i] = 0;
            if (serve[i] && din[i] != 8'h00) begin
                m_bus[i] = int'(din[i]); m_dir[i] = dir_in[i];
                m_run[i] = 1; m_elapsed[i] = 0;
            end
        end else begin
            m_elapsed[i]++;
            m_tick[i] = (m_elapsed[i] % pc(i)) == 0;
            if (m_tick[i]) begin
                b  = m_bus[i];
                nd = m_dir[i];
                if (m_dir[i] == 0) begin
                    if ((b % 2) == 1 && hit1[i]) begin b = (b * 2) % 256; nd = 1; end
                    else b = b / 2;
                end else begin
                    if (b >= 128 && hit2[i]) begin b = b / 2; nd = 0; end
                    else b = (b * 2) % 256;
                end
                if (b == 0) begin
                    m_run[i] = 0; m_side[i] = m_dir[i]; m_bus[i] = 0;
                end else begin
                    m_bus[i] = b; m_dir[i] = nd;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                check("model_bus", i, 32'(bus[i]), 32'(m_bus[i]));
                check("model_moving", i, 32'(moving[i]), 32'(m_run[i]));
                check("model_tick", i, 32'(tick[i]), 32'(m_tick[i]));
                if (!m_run[i]) check("model_side", i, 32'(side[i]), 32'(m_side[i]));
            end
        end
    end

    task automatic do_reset();
        rst[0] = 1; rst[1] = 1;
        repeat (2) @(negedge clk);
        rst[0] = 0; rst[1] = 0;
    endtask

    task automatic serve_one(input int i, input logic [7:0] d, input logic dr);
        serve[i] = 1; din[i] = d; dir_in[i] = dr;
        @(negedge clk);
        serve[i] = 0; din[i] = 8'h00;
    endtask

    task automatic wait_tick(input int i, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!tick[i] && cycles < 40);
        if (!tick[i]) check("tick_timeout", i, 32'(cycles), 32'd0);
    endtask

    initial begin
        int c;
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1; serve[i] = 0; din[i] = 0; dir_in[i] = 0; hit1[i] = 0; hit2[i] = 0;
        end
        @(negedge clk);
        do_reset();
        check_en = 1'b1;
        check("rst_bus", 0, 32'(bus[0]), 32'h0);
        check("rst_moving", 0, 32'(moving[0]), 32'h0);
        check("rst_tick", 0, 32'(tick[0]), 32'h0);
        check("rst_side", 0, 32'(side[0]), 32'h0);

        // Single ball toward player 1, no paddle: 08 -> 04 -> 02 -> 01 -> exit.
        serve_one(0, 8'h08, 1'b0);
        check("serve_bus", 0, 32'(bus[0]), 32'h08);
        check("serve_moving", 0, 32'(moving[0]), 32'h1);
        wait_tick(0, c); check("tick_latency", 0, 32'(c), 32'd4); check("shift1", 0, 32'(bus[0]), 32'h04);
        wait_tick(0, c); check("tick_period", 0, 32'(c), 32'd4); check("shift2", 0, 32'(bus[0]), 32'h02);
        wait_tick(0, c); check("shift3", 0, 32'(bus[0]), 32'h01);
        wait_tick(0, c);
        check("exit_bus", 0, 32'(bus[0]), 32'h00);
        check("exit_moving", 0, 32'(moving[0]), 32'h0);
        check("exit_side", 0, 32'(side[0]), 32'h0);

        // Bounce off player 1, travel to the MSB, exit past player 2.
        serve_one(0, 8'h01, 1'b0);
        hit1[0] = 1;
        wait_tick(0, c); check("bounce1", 0, 32'(bus[0]), 32'h02);
        hit1[0] = 0;
        for (int k = 2; k < 8; k++) begin
            wait_tick(0, c);
            e = 8'h01 << k;
            check("climb", 0, 32'(bus[0]), 32'(e));
        end
        wait_tick(0, c);
        check("exit2_bus", 0, 32'(bus[0]), 32'h00);
        check("exit2_side", 0, 32'(side[0]), 32'h1);

        // A zero-pattern serve is ignored.
        serve[0] = 1; din[0] = 8'h00; dir_in[0] = 1;
        repeat (3) @(negedge clk);
        serve[0] = 0;
        check("zero_serve_moving", 0, 32'(moving[0]), 32'h0);
        check("zero_serve_side", 0, 32'(side[0]), 32'h1);

        // Multi-bit pattern, with serve held during RUN (must not reload).
        serve_one(0, 8'h18, 1'b1);
        check("pattern_load", 0, 32'(bus[0]), 32'h18);
        serve[0] = 1; din[0] = 8'hFF; dir_in[0] = 0;
        wait_tick(0, c); check("pattern1", 0, 32'(bus[0]), 32'h30);
        wait_tick(0, c); check("pattern2", 0, 32'(bus[0]), 32'h60);
        serve[0] = 0;
        wait_tick(0, c); check("pattern3", 0, 32'(bus[0]), 32'hC0);
        wait_tick(0, c); check("pattern4", 0, 32'(bus[0]), 32'h80);
        wait_tick(0, c); check("pattern_exit", 0, 32'(bus[0]), 32'h00);
        check("pattern_side", 0, 32'(side[0]), 32'h1);

        // Reset in the middle of RUN.
        serve_one(0, 8'h08, 1'b1);
        serve[0] = 1; din[0] = 8'hFF;
        wait_tick(0, c); check("pre_rst1", 0, 32'(bus[0]), 32'h10);
        wait_tick(0, c); check("pre_rst2", 0, 32'(bus[0]), 32'h20);
        rst[0] = 1;
        @(negedge clk);
        rst[0] = 0; serve[0] = 0;
        check("midrst_bus", 0, 32'(bus[0]), 32'h00);
        check("midrst_moving", 0, 32'(moving[0]), 32'h0);
        check("midrst_tick", 0, 32'(tick[0]), 32'h0);

        // Prescale 1: shift on every RUN cycle.
        serve_one(1, 8'h80, 1'b0);
        check("p1_load", 1, 32'(bus[1]), 32'h80);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e = 8'h80 >> k;
            check("p1_tick", 1, 32'(tick[1]), 32'h1);
            check("p1_bus", 1, 32'(bus[1]), 32'(e));
        end
        check("p1_exit_moving", 1, 32'(moving[1]), 32'h0);
        check("p1_exit_side", 1, 32'(side[1]), 32'h0);

        // Randomized play on both instances.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                rst[i]    = ($urandom_range(0, 249) == 0);
                serve[i]  = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 3))
                    0: din[i] = 8'h00;
                    1: din[i] = 8'h01 << $urandom_range(0, 7);
                    default: din[i] = 8'($urandom_range(0, 255));
                endcase
                dir_in[i] = 1'($urandom_range(0, 1));
                hit1[i]   = 1'($urandom_range(0, 1));
                hit2[i]   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            rst[i] = 0; serve[i] = 0; hit1[i] = 0; hit2[i] = 0;
        end
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
